// File: rtl/uart_pkg.sv
// Shared UART package: default framing constants and the receiver state encoding.
package uart_pkg;

  // Default oversampling ratio and data width, shared by transmitter and receiver.
  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; both stages reset to the idle level (1).
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronization of the serial line into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: oversampled start detection, LSB-first deserialization, stop check,
// valid/ready output handshake with framing-error pulse and sticky overrun flag.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_ZERO = BW'(0);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  rx_state_e              state_r;
  logic [CW-1:0]          cnt_r;
  logic [BW-1:0]          bit_idx_r;
  logic [DATA_BITS-1:0]   shreg_r;
  logic [DATA_BITS-1:0]   rx_data_r;
  logic                   rx_valid_r;
  logic                   frame_err_r;
  logic                   overrun_r;
  logic                   rx_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Frame FSM, sample counter, shift register and registered handshake outputs.
  // The consumer-side clear is applied first so that a byte completing in the same
  // cycle as an accept wins and keeps rx_valid high without flagging overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= IDX_ZERO;
      shreg_r     <= {DATA_BITS{1'b0}};
      rx_data_r   <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (rx_valid_r && rx_ready) begin
        rx_valid_r <= 1'b0;
        overrun_r  <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          cnt_r <= CNT_ZERO;
          if (!rx_s) begin
            state_r <= START;
          end
        end
        START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= CNT_ZERO;
            if (!rx_s) begin
              state_r   <= DATA;
              bit_idx_r <= IDX_ZERO;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == CNT_FULL) begin
            cnt_r     <= CNT_ZERO;
            shreg_r   <= {rx_s, shreg_r[DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + IDX_ONE;
            if (bit_idx_r == IDX_LAST) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == CNT_FULL) begin
            cnt_r <= CNT_ZERO;
            if (rx_s) begin
              rx_data_r  <= shreg_r;
              rx_valid_r <= 1'b1;
              if (rx_valid_r && !rx_ready) begin
                overrun_r <= 1'b1;
              end
              state_r <= IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        BREAK: begin
          cnt_r <= CNT_ZERO;
          if (rx_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          cnt_r   <= CNT_ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: ideal N-clock-per-bit line driver, negedge monitor
// logging rx_valid rising edges and frame_err pulses, immediate-assertion checks.
module tb_uart_rx_deser;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  int         vcyc   = 0;
  int         ferr_n = 0;
  int         both_n = 0;
  logic       prev_v = 1'b0;

  uart_rx_deser #(.CLKS_PER_BIT(N), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle stamp: equals the number of posedges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && prev_v !== 1'b1) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(rx_data);
    end
    if (rx_valid === 1'b1) vcyc++;
    if (frame_err === 1'b1) ferr_n++;
    if (frame_err === 1'b1 && rx_valid === 1'b1) both_n++;
    prev_v = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(N);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, output int start);
    start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stopb);
  endtask

  task automatic clear_logs();
    rise_cyc.delete();
    rise_dat.delete();
    vcyc   = 0;
    ferr_n = 0;
  endtask

  function automatic int rise_at(input int i);
    if (i < rise_cyc.size()) return rise_cyc[i];
    else return -1;
  endfunction

  function automatic logic [7:0] dat_at(input int i);
    if (i < rise_dat.size()) return rise_dat[i];
    else return 8'hxx;
  endfunction

  initial begin
    int s0;
    int s1;

    // Reset
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_data", {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_ferr", {31'd0, frame_err}, 32'h0);
    chk("rst_ovr", {31'd0, overrun}, 32'h0);
    tick(5);

    // 1: single frame 0xA5, latency and one-cycle valid
    clear_logs();
    send_frame(8'hA5, 1'b1, s0);
    tick(20);
    chk("t1_count", rise_cyc.size(), 32'd1);
    chk("t1_data", {24'd0, dat_at(0)}, 32'hA5);
    chk("t1_lat", rise_at(0) - s0, 32'd155);
    chk("t1_vcyc", vcyc, 32'd1);
    chk("t1_ferr", ferr_n, 32'd0);
    chk("t1_ovr", {31'd0, overrun}, 32'h0);

    // 2: back-to-back 0x00 then 0xFF
    clear_logs();
    send_frame(8'h00, 1'b1, s0);
    send_frame(8'hFF, 1'b1, s1);
    tick(20);
    chk("t2_count", rise_cyc.size(), 32'd2);
    chk("t2_data0", {24'd0, dat_at(0)}, 32'h00);
    chk("t2_data1", {24'd0, dat_at(1)}, 32'hFF);
    chk("t2_gap", rise_at(1) - rise_at(0), 32'd160);
    chk("t2_lat", rise_at(0) - s0, 32'd155);

    // 3: 4-cycle glitch rejected, then 0x3C received
    clear_logs();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    chk("t3_glitch_valid", rise_cyc.size(), 32'd0);
    chk("t3_glitch_ferr", ferr_n, 32'd0);
    send_frame(8'h3C, 1'b1, s0);
    tick(20);
    chk("t3_count", rise_cyc.size(), 32'd1);
    chk("t3_data", {24'd0, dat_at(0)}, 32'h3C);
    chk("t3_lat", rise_at(0) - s0, 32'd155);

    // 4: bad stop bit, line held low, then released
    clear_logs();
    send_frame(8'h3C, 1'b0, s0);
    tick(50);
    chk("t4_ferr", ferr_n, 32'd1);
    chk("t4_valid", rise_cyc.size(), 32'd0);
    rx = 1'b1;
    tick(200);
    chk("t4_ferr_after", ferr_n, 32'd1);
    chk("t4_valid_after", rise_cyc.size(), 32'd0);

    // 5: overrun with rx_ready=0, then a single accept
    clear_logs();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, s0);
    send_frame(8'h22, 1'b1, s1);
    tick(10);
    chk("t5_rises", rise_cyc.size(), 32'd1);
    chk("t5_valid", {31'd0, rx_valid}, 32'h1);
    chk("t5_data", {24'd0, rx_data}, 32'h22);
    chk("t5_ovr", {31'd0, overrun}, 32'h1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("t5_acc_valid", {31'd0, rx_valid}, 32'h0);
    chk("t5_acc_ovr", {31'd0, overrun}, 32'h0);
    chk("t5_acc_data", {24'd0, rx_data}, 32'h22);

    // 6: reset mid-DATA of 0xFF, then 0x5A
    clear_logs();
    rx_ready = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("t6_rst_data", {24'd0, rx_data}, 32'h0);
    chk("t6_rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("t6_rst_ovr", {31'd0, overrun}, 32'h0);
    chk("t6_rst_ferr", {31'd0, frame_err}, 32'h0);
    tick(200);
    chk("t6_abort_valid", rise_cyc.size(), 32'd0);
    chk("t6_abort_ferr", ferr_n, 32'd0);
    send_frame(8'h5A, 1'b1, s0);
    tick(20);
    chk("t6_count", rise_cyc.size(), 32'd1);
    chk("t6_data", {24'd0, dat_at(0)}, 32'h5A);
    chk("t6_lat", rise_at(0) - s0, 32'd155);

    // frame_err and rx_valid never coincide
    chk("never_both", both_n, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
